noise_generator: RTL

//  Pseudo-random noise source for the digital synthesizer. It drives the
//  12-bit noise sample bus (DATA_FROM_NOISE) consumed by the downstream
//  3-stage delay buffer. A 32-bit Galois LFSR produces samples that are

---
 rtl/noise_generator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/noise_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : noise_generator
//  Brief    : Galois-LFSR noise source with amplitude scaling, offset-binary
//             output, burst or continuous mode.
//  Revision : 1.0
// ============================================================================
module noise_generator #(
  parameter int                  DATA_WIDTH = 12,
  parameter int                  LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK = 32'h80200003,
  parameter logic [LFSR_WIDTH-1:0] SEED     = 32'hACE12468,
  parameter int                  LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  SEED_LOAD,
  input  logic [LFSR_WIDTH-1:0] SEED_IN,
  input  logic [DATA_WIDTH-1:0] AMPLITUDE,
  input  logic [LEN_WIDTH-1:0]  BURST_LEN,
  output logic [DATA_WIDTH-1:0] NOISE_OUT,
  output logic                  NOISE_VALID,
  output logic                  BUSY
);

  localparam int c_PROD_W = 2 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] c_OFFSET = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state, w_state_next;
  logic [LFSR_WIDTH-1:0]  r_lfsr, w_lfsr_next, w_lfsr_step;
  logic [LEN_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0]  r_gain, w_gain_next;
  logic                   w_emit;

  logic signed [c_PROD_W-1:0] w_s_ext, w_g_ext, w_prod, r_prod;
  logic                       r_v1;
  logic [DATA_WIDTH-1:0]      r_noise_out;
  logic                       r_noise_valid;
  logic                       w_unused_prod;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAP_MASK) : (r_lfsr >> 1);

  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = r_lfsr;
    w_cnt_next   = r_cnt;
    w_gain_next  = r_gain;
    w_emit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_next = ST_RUN;
          w_gain_next  = AMPLITUDE;
          w_cnt_next   = BURST_LEN;
        end else if (SEED_LOAD) begin
          // A zero seed would lock the LFSR, so fall back to the default seed
          w_lfsr_next = (SEED_IN == '0) ? SEED : SEED_IN;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          w_state_next = ST_IDLE;
        end else begin
          w_emit      = 1'b1;
          w_lfsr_next = w_lfsr_step;
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - LEN_WIDTH'(1);
            if (r_cnt == LEN_WIDTH'(1)) w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_lfsr  <= SEED;
      r_cnt   <= '0;
      r_gain  <= '0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= w_lfsr_next;
      r_cnt   <= w_cnt_next;
      r_gain  <= w_gain_next;
    end
  end

  // Signed sample times unsigned gain; the full product fits the 25-bit width
  assign w_s_ext = {{(DATA_WIDTH+1){r_lfsr[DATA_WIDTH-1]}}, r_lfsr[DATA_WIDTH-1:0]};
  assign w_g_ext = {{(DATA_WIDTH+1){1'b0}}, r_gain};
  assign w_prod  = w_s_ext * w_g_ext;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prod        <= '0;
      r_v1          <= 1'b0;
      r_noise_out   <= c_OFFSET;
      r_noise_valid <= 1'b0;
    end else begin
      r_v1          <= w_emit;
      r_noise_valid <= r_v1;
      if (w_emit) r_prod <= w_prod;
      // Bits [2W-1:W] of the product equal (prod >>> W) truncated to W bits
      if (r_v1) r_noise_out <= r_prod[DATA_WIDTH +: DATA_WIDTH] + c_OFFSET;
    end
  end

  assign w_unused_prod = ^{r_prod[c_PROD_W-1], r_prod[DATA_WIDTH-1:0]};

  assign NOISE_OUT   = r_noise_out;
  assign NOISE_VALID = r_noise_valid;
  assign BUSY        = (r_state == ST_RUN) | r_v1 | r_noise_valid;

endmodule
`default_nettype wire
